frame_serdes_timer: RTL

//  Parametrised symbol timer + frame serializer/deserializer for the CRC/4FSK link.

---
 rtl/frame_serdes_timer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/frame_serdes_timer.sv
// frame_serdes_timer: symbol timer plus frame serializer/deserializer for the
// CRC/4FSK link. clk_sys is divided into symbols of PHASE_LEN cycles, and
// FRAME_BITS symbols make one frame.
//
// TX: a valid/ready handshake loads a holding register. At the end of a frame,
// the held word moves into the shift register and is sent LSB first, one bit
// per symbol.
// RX: rx_bit is sampled once per symbol at SAMPLE_PHASE. When the last symbol
// is sampled, the complete word is published with a one-cycle rx_valid pulse.
//
// Optional feature: define FRAME_SYNC_EN to add the `sync` input. sync
// realigns the timer to the start of a frame. It also aborts the frame that is
// currently being sent and discards the partially received word.
module frame_serdes_timer #(
  parameter int FRAME_BITS   = 16,
  parameter int PHASE_LEN    = 256,
  parameter int SAMPLE_PHASE = 0,
  localparam int PW = $clog2(PHASE_LEN),
  localparam int CW = $clog2(FRAME_BITS)
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_bit,
  output logic                  tx_active,
  input  logic                  rx_bit,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic [PW-1:0]         phase,
  output logic [CW-1:0]         sign_cnt,
  output logic                  sign_clk
`ifdef FRAME_SYNC_EN
  ,
  input  logic                  sync
`endif
);

  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_LEN - 1);
  localparam logic [PW-1:0] SAMPLE_AT  = PW'(SAMPLE_PHASE);
  localparam logic [CW-1:0] SIGN_LAST  = CW'(FRAME_BITS - 1);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Realignment request. This signal is tied low when the feature is absent,
  // so the rest of the logic is the same in both builds.
  // ---------------------------------------------------------------------------
  logic sync_hit;
`ifdef FRAME_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Symbol / frame timer
  // ---------------------------------------------------------------------------
  logic symbol_end;
  logic frame_end;

  assign symbol_end = (phase == PHASE_LAST);
  assign frame_end  = symbol_end && (sign_cnt == SIGN_LAST);
  assign sign_clk   = (phase == '0);

  // Phase counts cycles within a symbol; sign_cnt counts symbols within a frame.
  always_ff @(posedge clk_sys) begin
    // NOTE: every register here is updated with <=, so each process reads the
    // values from before the edge. Using = would make the result depend on the
    // order in which processes are evaluated.
    if (reset) begin
      phase    <= '0;
      sign_cnt <= '0;
    end else if (sync_hit) begin
      phase    <= '0;
      sign_cnt <= '0;
    end else if (symbol_end) begin
      phase    <= '0;
      sign_cnt <= (sign_cnt == SIGN_LAST) ? '0 : sign_cnt + 1'b1;
    end else begin
      phase    <= phase + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX path: holding register -> shift register -> tx_bit
  // ---------------------------------------------------------------------------
  tx_state_t             tx_state_q;
  tx_state_t             tx_state_d;
  logic [FRAME_BITS-1:0] hold_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  pending_q;
  logic                  accept;
  logic                  load;

  assign tx_ready = ~pending_q;
  assign accept   = tx_valid && tx_ready;
  // A word accepted during the frame-end cycle is not pending yet, so it waits
  // until the next frame end.
  assign load     = frame_end && pending_q && !sync_hit;

  // TX state register.
  always_ff @(posedge clk_sys) begin
    if (reset) tx_state_q <= TX_IDLE;
    else       tx_state_q <= tx_state_d;
  end

  // Next TX state. The state changes only at a frame end or on realignment.
  always_comb begin
    // NOTE: assigning the default first means every path drives tx_state_d,
    // so no latch can be inferred.
    tx_state_d = tx_state_q;
    if (sync_hit) begin
      tx_state_d = TX_IDLE;
    end else if (frame_end) begin
      tx_state_d = load ? TX_SEND : TX_IDLE;
    end
  end

  // Holding register and shift register. The shift register is loaded from
  // the held word at a frame end.
  always_ff @(posedge clk_sys) begin
    // NOTE: these data registers are plain flops, not a RAM. Clearing them on
    // reset costs almost nothing, and it guarantees that no stale word can
    // reappear after a reset or an aborted frame.
    if (reset) begin
      hold_q    <= '0;
      shift_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (sync_hit)  shift_q <= '0;
      else if (load) shift_q <= hold_q;

      if (load) begin
        pending_q <= 1'b0;
      end else if (accept) begin
        hold_q    <= tx_data;
        pending_q <= 1'b1;
      end
    end
  end

  assign tx_active = (tx_state_q == TX_SEND);
  assign tx_bit    = tx_active & shift_q[sign_cnt];

  // ---------------------------------------------------------------------------
  // RX path: one sample per symbol, word published after the last symbol
  // ---------------------------------------------------------------------------
  logic [FRAME_BITS-1:0] rx_shift_q;
  logic [FRAME_BITS-1:0] rx_word;
  logic                  sample;

  assign sample = (phase == SAMPLE_AT);

  // rx_word is the received word with the bit being sampled this cycle already
  // inserted, so the last bit is included in the published word.
  always_comb begin
    rx_word           = rx_shift_q;
    rx_word[sign_cnt] = rx_bit;
  end

  // Receive shift register, output word and valid strobe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rx_shift_q <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else if (sync_hit) begin
      rx_shift_q <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (sample) begin
        rx_shift_q <= rx_word;
        if (sign_cnt == SIGN_LAST) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule
